// File: rtl/svci_pkg.sv
// Shared SVCI encodings: command opcodes, response kinds, error codes and the
// client-to-command opcode mapping.
package svci_pkg;

   localparam logic [2:0] OPC_RD    = 3'b000;
   localparam logic [2:0] OPC_WR_P  = 3'b010;
   localparam logic [2:0] OPC_WR_NP = 3'b011;

   localparam logic [1:0] RSP_RD    = 2'b00;
   localparam logic [1:0] RSP_WR_P  = 2'b10;
   localparam logic [1:0] RSP_WR_NP = 2'b11;

   typedef enum logic [1:0] {
      ERR_OK   = 2'b00,
      ERR_SLV  = 2'b01,
      ERR_DEC  = 2'b10,
      ERR_ALGN = 2'b11
   } svci_err_e;

   function automatic logic [2:0] cmd_opc(input logic write, input logic posted);
      if (!write) return OPC_RD;
      return posted ? OPC_WR_P : OPC_WR_NP;
   endfunction

endpackage

// File: rtl/svci_tag_alloc.sv
// Tag pool: outstanding bitmap, per-tag write flag, lowest-free allocator and
// response consistency check against the registered pool state.
module svci_tag_alloc #(
   parameter int TAG = 2
) (
   input  logic           clk,
   input  logic           rst_l,
   input  logic           set_i,
   input  logic           set_wr_i,
   input  logic           cmd_rel_i,
   input  logic [TAG-1:0] cmd_tag_i,
   input  logic           rsp_rel_i,
   input  logic [TAG-1:0] rsp_tag_i,
   input  logic           rsp_wr_i,
   output logic           any_free_o,
   output logic [TAG-1:0] alloc_tag_o,
   output logic           mismatch_o
);

   localparam int NT = 2**TAG;

   logic [NT-1:0]  out_q, out_d;
   logic [NT-1:0]  wr_q, wr_d;
   logic [TAG-1:0] alloc_tag;

   // Descending scan so the lowest free index is the last one written.
   always_comb begin
      alloc_tag = '0;
      for (int i = NT-1; i >= 0; i--) begin
         if (!out_q[i]) alloc_tag = TAG'(i);
      end
   end

   assign alloc_tag_o = alloc_tag;
   assign any_free_o  = ~&out_q;
   assign mismatch_o  = ~out_q[rsp_tag_i] | (wr_q[rsp_tag_i] != rsp_wr_i);

   always_comb begin
      out_d = out_q;
      wr_d  = wr_q;
      if (cmd_rel_i) out_d[cmd_tag_i] = 1'b0;
      if (rsp_rel_i) out_d[rsp_tag_i] = 1'b0;
      if (set_i) begin
         out_d[alloc_tag] = 1'b1;
         wr_d[alloc_tag]  = set_wr_i;
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         out_q <= '0;
         wr_q  <= '0;
      end else begin
         out_q <= out_d;
         wr_q  <= wr_d;
      end
   end

endmodule

// File: rtl/svci_tag_issuer.sv
// SVCI command master: tags client requests from a free pool, issues them through a
// one-entry command register and returns matched responses through a registered stage.
module svci_tag_issuer
   import svci_pkg::*;
#(
   parameter int TAG     = 2,
   parameter int ID      = 1,
   parameter int PRTY    = 1,
   parameter int MID_VAL = 0
) (
   input  logic            clk,
   input  logic            rst_l,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_write,
   input  logic            req_posted,
   input  logic [31:0]     req_addr,
   input  logic [63:0]     req_wdata,
   input  logic [7:0]      req_wbe,
   input  logic [2:0]      req_length,
   output logic            svci_cmd_valid,
   input  logic            svci_cmd_ready,
   output logic [TAG-1:0]  svci_cmd_tag,
   output logic [ID-1:0]   svci_cmd_mid,
   output logic [31:0]     svci_cmd_addr,
   output logic [63:0]     svci_cmd_wdata,
   output logic [7:0]      svci_cmd_wbe,
   output logic [2:0]      svci_cmd_length,
   output logic [2:0]      svci_cmd_opc,
   output logic [PRTY-1:0] svci_cmd_prty,
   input  logic            svci_rsp_valid,
   output logic            svci_rsp_ready,
   input  logic [TAG-1:0]  svci_rsp_tag,
   input  logic [ID-1:0]   svci_rsp_mid,
   input  logic [63:0]     svci_rsp_rdata,
   input  logic [3:0]      svci_rsp_opc,
   input  logic [PRTY-1:0] svci_rsp_prty,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [TAG-1:0]  rsp_tag,
   output logic [63:0]     rsp_rdata,
   output logic            rsp_write,
   output logic            rsp_posted,
   output logic [1:0]      rsp_err,
   output logic            err_unexp
);

   logic           any_free, mismatch;
   logic [TAG-1:0] alloc_tag;
   logic           req_fire, cmd_fire, srsp_fire, rsp_track;

   logic           cmd_vld_q, cmd_vld_d;
   logic [TAG-1:0] cmd_tag_q, cmd_tag_d;
   logic [31:0]    cmd_addr_q, cmd_addr_d;
   logic [63:0]    cmd_wdata_q, cmd_wdata_d;
   logic [7:0]     cmd_wbe_q, cmd_wbe_d;
   logic [2:0]     cmd_len_q, cmd_len_d;
   logic [2:0]     cmd_opc_q, cmd_opc_d;

   logic           rsp_vld_q, rsp_vld_d;
   logic [TAG-1:0] rsp_tag_q, rsp_tag_d;
   logic [63:0]    rsp_rdata_q, rsp_rdata_d;
   logic           rsp_write_q, rsp_write_d;
   logic           rsp_posted_q, rsp_posted_d;
   svci_err_e      rsp_err_q, rsp_err_d;
   logic           err_unexp_q, err_unexp_d;

   logic           unused_rsp;

   assign unused_rsp = ^{svci_rsp_mid, svci_rsp_prty};

   assign req_ready      = (~cmd_vld_q | svci_cmd_ready) & any_free;
   assign req_fire       = req_valid & req_ready;
   assign cmd_fire       = cmd_vld_q & svci_cmd_ready;
   assign svci_rsp_ready = ~rsp_vld_q | rsp_ready;
   assign srsp_fire      = svci_rsp_valid & svci_rsp_ready;
   // Posted-write error responses carry no live tag, so they bypass the pool.
   assign rsp_track      = srsp_fire & (svci_rsp_opc[3:2] != RSP_WR_P);

   svci_tag_alloc #(.TAG(TAG)) u_alloc (
      .clk         (clk),
      .rst_l       (rst_l),
      .set_i       (req_fire),
      .set_wr_i    (req_write),
      .cmd_rel_i   (cmd_fire & (cmd_opc_q == OPC_WR_P)),
      .cmd_tag_i   (cmd_tag_q),
      .rsp_rel_i   (rsp_track),
      .rsp_tag_i   (svci_rsp_tag),
      .rsp_wr_i    (svci_rsp_opc[3]),
      .any_free_o  (any_free),
      .alloc_tag_o (alloc_tag),
      .mismatch_o  (mismatch)
   );

   always_comb begin
      cmd_vld_d   = req_fire | (cmd_vld_q & ~svci_cmd_ready);
      cmd_tag_d   = cmd_tag_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_wdata_d = cmd_wdata_q;
      cmd_wbe_d   = cmd_wbe_q;
      cmd_len_d   = cmd_len_q;
      cmd_opc_d   = cmd_opc_q;
      if (req_fire) begin
         cmd_tag_d   = alloc_tag;
         cmd_addr_d  = req_addr;
         cmd_wdata_d = req_wdata;
         cmd_wbe_d   = req_wbe;
         cmd_len_d   = req_length;
         cmd_opc_d   = cmd_opc(req_write, req_posted);
      end
   end

   always_comb begin
      rsp_vld_d    = srsp_fire | (rsp_vld_q & ~rsp_ready);
      rsp_tag_d    = rsp_tag_q;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_write_d  = rsp_write_q;
      rsp_posted_d = rsp_posted_q;
      rsp_err_d    = rsp_err_q;
      err_unexp_d  = err_unexp_q | (rsp_track & mismatch);
      if (srsp_fire) begin
         rsp_tag_d    = svci_rsp_tag;
         rsp_rdata_d  = svci_rsp_rdata;
         rsp_write_d  = svci_rsp_opc[3];
         rsp_posted_d = svci_rsp_opc[3] & ~svci_rsp_opc[2];
         rsp_err_d    = svci_err_e'(svci_rsp_opc[1:0]);
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         cmd_vld_q    <= 1'b0;
         cmd_tag_q    <= '0;
         cmd_addr_q   <= '0;
         cmd_wdata_q  <= '0;
         cmd_wbe_q    <= '0;
         cmd_len_q    <= '0;
         cmd_opc_q    <= '0;
         rsp_vld_q    <= 1'b0;
         rsp_tag_q    <= '0;
         rsp_rdata_q  <= '0;
         rsp_write_q  <= 1'b0;
         rsp_posted_q <= 1'b0;
         rsp_err_q    <= ERR_OK;
         err_unexp_q  <= 1'b0;
      end else begin
         cmd_vld_q    <= cmd_vld_d;
         cmd_tag_q    <= cmd_tag_d;
         cmd_addr_q   <= cmd_addr_d;
         cmd_wdata_q  <= cmd_wdata_d;
         cmd_wbe_q    <= cmd_wbe_d;
         cmd_len_q    <= cmd_len_d;
         cmd_opc_q    <= cmd_opc_d;
         rsp_vld_q    <= rsp_vld_d;
         rsp_tag_q    <= rsp_tag_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_write_q  <= rsp_write_d;
         rsp_posted_q <= rsp_posted_d;
         rsp_err_q    <= rsp_err_d;
         err_unexp_q  <= err_unexp_d;
      end
   end

   assign svci_cmd_valid  = cmd_vld_q;
   assign svci_cmd_tag    = cmd_tag_q;
   assign svci_cmd_mid    = ID'(MID_VAL);
   assign svci_cmd_addr   = cmd_addr_q;
   assign svci_cmd_wdata  = cmd_wdata_q;
   assign svci_cmd_wbe    = cmd_wbe_q;
   assign svci_cmd_length = cmd_len_q;
   assign svci_cmd_opc    = cmd_opc_q;
   assign svci_cmd_prty   = {PRTY{^cmd_addr_q}};

   assign rsp_valid  = rsp_vld_q;
   assign rsp_tag    = rsp_tag_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign rsp_write  = rsp_write_q;
   assign rsp_posted = rsp_posted_q;
   assign rsp_err    = rsp_err_q;
   assign err_unexp  = err_unexp_q;

endmodule
